// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - state_e        : scanner FSM states
//   - ROWS_IDLE      : synchronised row value when no key pulls a row low
//   - KEY_* fields   : layout of the 4-bit key code {row_idx, col_idx}
//   - lowest_low_row : priority pick of the lowest-index active-low row
//   - make_key_code  : packs a row/column pair into the key-code layout
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Key code layout: row index in the upper pair, column index in the lower pair.
  localparam int KEY_IDX_W   = 2;
  localparam int KEY_COL_LSB = 0;
  localparam int KEY_ROW_LSB = KEY_COL_LSB + KEY_IDX_W;
  localparam int KEY_CODE_W  = 2 * KEY_IDX_W;

  // Lowest-index row that reads low. Scanning from the top down lets the
  // lowest index overwrite any higher one. Returns 0 for an idle pattern;
  // callers only use it once a low row has been seen.
  function automatic logic [KEY_IDX_W-1:0] lowest_low_row(input logic [3:0] rows_n);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [KEY_CODE_W-1:0] make_key_code(
    input logic [KEY_IDX_W-1:0] row_idx,
    input logic [KEY_IDX_W-1:0] col_idx
  );
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    code[KEY_ROW_LSB +: KEY_IDX_W] = row_idx;
    code[KEY_COL_LSB +: KEY_IDX_W] = col_idx;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2
//   Two-flop synchroniser for the asynchronous keypad row lines. Both stages
//   reset to 1 so that an idle (pulled-up) keypad is seen during and just
//   after reset, never a phantom press.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     d      in  WIDTH asynchronous inputs
//     q      out WIDTH synchronised outputs (2 cycles of latency)
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its input from before the clock edge; blocking assignments
  // here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   press and the release, and produces exactly one key_valid strobe per
//   physical press together with its 4-bit key code {row_idx, col_idx}.
//   Parameters:
//     SCAN_DIV      dwell cycles per column, at least 4 (rows need two sync
//                   cycles plus settling after a column change)
//     DEBOUNCE_CYC  stable cycles required to accept a press or a release,
//                   at least 2
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     row_n[3:0] in   keypad rows, active-low, asynchronous to clk
//     col_n[3:0] out  column drive, one-cold (registered)
//     key_code   out  code of the last accepted key, held until the next one
//     key_valid  out  one-cycle strobe, key_code valid in the same cycle
//     key_down   out  high from accept until the release is debounced
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  // Synchronised rows; nothing downstream ever looks at raw row_n.
  logic [3:0] rs;

  sync2 #(
    .WIDTH (4)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rs)
  );

  state_e                 state_q,     state_d;
  logic [KEY_IDX_W-1:0]   col_idx_q,   col_idx_d;
  logic [DIV_W-1:0]       div_cnt_q,   div_cnt_d;
  logic [DB_W-1:0]        db_cnt_q,    db_cnt_d;
  logic [KEY_IDX_W-1:0]   row_idx_q,   row_idx_d;
  logic [3:0]             pat_q,       pat_d;
  logic [3:0]             col_n_q,     col_n_d;
  logic [KEY_CODE_W-1:0]  key_code_q,  key_code_d;
  logic                   key_valid_q, key_valid_d;
  logic                   key_down_q,  key_down_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch; each state only overrides what
  // it changes.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    div_cnt_d   = div_cnt_q;
    db_cnt_d    = db_cnt_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    unique case (state_q)
      SCAN: begin
        // Rows are only looked at on the last dwell cycle, which gives the
        // newly driven column time to settle through the synchroniser.
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else if (rs != ROWS_IDLE) begin
          row_idx_d = lowest_low_row(rs);
          pat_d     = rs;
          db_cnt_d  = '0;
          state_d   = DEBOUNCE;
        end else begin
          col_idx_d = col_idx_q + 1'b1;
          div_cnt_d = '0;
        end
      end

      DEBOUNCE: begin
        // The whole row pattern must stay put, not just the chosen row, so a
        // second key bouncing in the same column also restarts the count.
        if (rs != pat_q) begin
          db_cnt_d  = '0;
          div_cnt_d = '0;
          state_d   = SCAN;
        end else if (db_cnt_q == DB_LAST) begin
          key_code_d  = make_key_code(row_idx_q, col_idx_q);
          key_valid_d = 1'b1;
          key_down_d  = 1'b1;
          db_cnt_d    = '0;
          state_d     = HELD;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        // Column stays frozen; extra keys in this column are ignored.
        if (rs == ROWS_IDLE) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        // A release bounce goes back to HELD silently: the press was
        // already reported once.
        if (rs != ROWS_IDLE) begin
          db_cnt_d = '0;
          state_d  = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          key_down_d = 1'b0;
          col_idx_d  = col_idx_q + 1'b1;
          div_cnt_d  = '0;
          db_cnt_d   = '0;
          state_d    = SCAN;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    // Decoded from the next column index so col_n is a plain register and
    // changes in the same cycle as col_idx.
    col_n_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      div_cnt_q   <= '0;
      db_cnt_q    <= '0;
      row_idx_q   <= '0;
      pat_q       <= ROWS_IDLE;
      col_n_q     <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      div_cnt_q   <= div_cnt_d;
      db_cnt_q    <= db_cnt_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
